// File: rtl/lut_cfg_loader_if.sv
// lut_cfg_if: valid/ready config word stream feeding lut_cfg_loader.
interface lut_cfg_if #(
    parameter int CONFIG_WIDTH = 1
);
    logic                    s_valid;
    logic                    s_ready;
    logic [CONFIG_WIDTH-1:0] s_data;
    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: shifts a config bitstream into a daisy-chained LUT group and reports completion.
// Define LUT_CFG_READBACK_EN to add a recirculating readback pass that checks an XOR-fold of the chain.
module lut_cfg_loader #(
    parameter int NUM_LUTS     = 1,
    parameter int LUT_NINPUTS  = 4,
    parameter int CONFIG_WIDTH = 1,
    localparam int TOTAL_BEATS = NUM_LUTS * (2 ** LUT_NINPUTS) / CONFIG_WIDTH,
    localparam int BW          = $clog2(TOTAL_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    lut_cfg_if.slave                s,
    output logic                    config_en,
    output logic [CONFIG_WIDTH-1:0] config_in,
    input  logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [BW-1:0]           beat_count
);
    if (((2 ** LUT_NINPUTS) % CONFIG_WIDTH) != 0) begin : g_bad_width
        $error("CONFIG_WIDTH must divide 2**LUT_NINPUTS");
    end

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
    state_t state;
    logic   hs, last;

    assign hs        = s.s_valid && s.s_ready;
    assign last      = beat_count == BW'(TOTAL_BEATS - 1);
    // VERIFY recirculates the tail back into the head so the chain ends where it started
    assign config_en = hs || state == VERIFY;
    assign config_in = state == LOAD ? s.s_data : state == VERIFY ? config_out : '0;

`ifdef LUT_CFG_READBACK_EN
    logic [CONFIG_WIDTH-1:0] chk_in, chk_out;
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s.s_ready  <= 1'b0;
`ifdef LUT_CFG_READBACK_EN
            cfg_err    <= 1'b0;
            chk_in     <= '0;
            chk_out    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        beat_count <= '0;
                        s.s_ready  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef LUT_CFG_READBACK_EN
                        cfg_err    <= 1'b0;
                        chk_in     <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (hs) begin
                        beat_count <= beat_count + BW'(1);
`ifdef LUT_CFG_READBACK_EN
                        chk_in     <= chk_in ^ s.s_data;
                        if (last) begin
                            state      <= VERIFY;
                            beat_count <= '0;
                            s.s_ready  <= 1'b0;
                            chk_out    <= '0;
                        end
`else
                        if (last) begin
                            state     <= DONE;
                            s.s_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
`ifdef LUT_CFG_READBACK_EN
                    beat_count <= beat_count + BW'(1);
                    chk_out    <= chk_out ^ config_out;
                    if (last) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cfg_err <= chk_in != (chk_out ^ config_out);
                    end
`else
                    state <= IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: table-driven load sequence plus directed corner cases against a 16-bit chain model.
module tb_lut_cfg_loader;
    logic       clk = 1'b0;
    logic       rst, start;
    logic       config_en, busy, done, cfg_err, corrupt = 1'b0;
    logic [0:0] config_in, config_out;
    logic [4:0] beat_count;
    logic [15:0] chain = '0;
    int n_checks = 0, n_fail = 0;

    lut_cfg_if #(.CONFIG_WIDTH(1)) bus ();

    lut_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .s(bus),
        .config_en(config_en), .config_in(config_in), .config_out(config_out),
        .busy(busy), .done(done), .cfg_err(cfg_err), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (config_en) chain <= {chain[14:0], config_in[0]};
    assign config_out[0] = chain[15] ^ corrupt;

    typedef struct {
        logic st, v, d;
        logic rdy, en, bsy, dn, rc, cin;
        int   bc;
    } vec_t;
    vec_t tbl[40];
    int n = 0;

    task automatic add(input logic st, v, d, rdy, en, bsy, dn, rc, cin, input int bc);
        tbl[n] = '{st: st, v: v, d: d, rdy: rdy, en: en, bsy: bsy, dn: dn, rc: rc, cin: cin, bc: bc};
        n++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int lim);
        int i;
        for (i = 0; i < lim && !done; i++) @(negedge clk);
        chk("done_within_bound", int'(done), 1);
    endtask

    task automatic load16(input logic [15:0] p);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            bus.s_valid = 1'b1;
            bus.s_data  = p[k];
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] pat, pat2;
        logic [15:0] snap;
        pat  = 16'b0110_1001_0000_1111;
        pat2 = 16'hC3A5;
        rst = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_config_en", int'(config_en), 0);
        chk("rst_config_in", int'(config_in), 0);
        chk("rst_beat_count", int'(beat_count), 0);
        rst = 1'b0;

        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) add(0, 1, pat[16-k], 1, 1, 1, 0, 0, pat[16-k], k - 1);
`ifdef LUT_CFG_READBACK_EN
        for (int k = 0; k < 16; k++) add(0, 0, 0, 0, 1, 1, 0, 1, 0, k);
`endif
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 16);

        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            start = tbl[r].st; bus.s_valid = tbl[r].v; bus.s_data = tbl[r].d;
            #1;
            chk($sformatf("row%0d_s_ready", r), int'(bus.s_ready), int'(tbl[r].rdy));
            chk($sformatf("row%0d_config_en", r), int'(config_en), int'(tbl[r].en));
            chk($sformatf("row%0d_busy", r), int'(busy), int'(tbl[r].bsy));
            chk($sformatf("row%0d_done", r), int'(done), int'(tbl[r].dn));
            chk($sformatf("row%0d_beat_count", r), int'(beat_count), tbl[r].bc);
            chk($sformatf("row%0d_config_in", r), int'(config_in), tbl[r].rc ? int'(chain[15]) : int'(tbl[r].cin));
        end
        chk("chain_pattern", int'(chain), int'(pat));
        chk("cfg_err_clean", int'(cfg_err), 0);

        // s_valid while DONE must not shift the chain
        snap = chain;
        @(negedge clk); bus.s_valid = 1'b1; bus.s_data = 1'b1; #1;
        chk("done_valid_en", int'(config_en), 0);
        chk("done_valid_ready", int'(bus.s_ready), 0);
        @(negedge clk); bus.s_valid = 1'b0; #1;
        chk("done_hold_count", int'(beat_count), 16);
        chk("done_hold_done", int'(done), 1);
        chk("done_chain_hold", int'(chain), int'(snap));

        // gapped beats with a stray start, then async reset mid-LOAD
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = (i == 5); bus.s_valid = (i % 2 == 0); bus.s_data = 1'b1;
            #1;
            chk($sformatf("gap%0d_en", i), int'(config_en), i % 2 == 0 ? 1 : 0);
            chk($sformatf("gap%0d_bc", i), int'(beat_count), (i + 1) / 2);
        end
        @(negedge clk); start = 1'b0; bus.s_valid = 1'b0; #1;
        chk("gap_final_bc", int'(beat_count), 7);
        chk("gap_busy", int'(busy), 1);
        bus.s_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(bus.s_ready), 0);
        chk("arst_en", int'(config_en), 0);
        chk("arst_bc", int'(beat_count), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("idle_valid_en", int'(config_en), 0);
        @(negedge clk); bus.s_valid = 1'b0; #1;
        chk("idle_valid_bc", int'(beat_count), 0);
        chk("idle_valid_busy", int'(busy), 0);

        load16(pat2);
        wait_done(40);
        chk("reload_chain", int'(chain), int'(pat2));
        chk("reload_bc", int'(beat_count), 16);
        chk("reload_cfg_err", int'(cfg_err), 0);

`ifdef LUT_CFG_READBACK_EN
        load16(pat);
        corrupt = 1'b1;
        @(negedge clk);
        corrupt = 1'b0;
        wait_done(40);
        chk("corrupt_cfg_err", int'(cfg_err), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
